pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: RUN/LOAD/HALT control, branch and jump target
// selection, and a return-address stack with sticky overflow/underflow flags.
module pc_sequencer #(
  parameter int PC_W      = 11,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_load,
  input  logic            data_load,
  input  logic            load_valid,
  input  logic            stall,
  input  logic            halt,
  input  logic [1:0]      is_jump,
  input  logic [1:0]      jmp_sel,
  input  logic            br_taken,
  input  logic [15:0]     br_off,
  input  logic [PC_W-1:0] jmp_tgt,
  input  logic [PC_W-1:0] reg_tgt,
  output logic [PC_W-1:0] pc_curr,
  output logic [PC_W-1:0] link_addr,
  output logic [1:0]      state,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_ovf,
  output logic            ras_unf
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W = $clog2(RAS_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_LOAD = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  state_e            state_r, state_nxt_s;
  logic [PC_W-1:0]   pc_r, pc_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [PC_W-1:0]   ras_mem_r [RAS_DEPTH];
  logic              ovf_r, unf_r;
  logic              push_s, ovf_set_s, unf_set_s, load_req_s;
  logic [IDX_W-1:0]  top_idx_s;
  logic [PC_W-1:0]   br_off_s, br_tgt_s, top_s;

  assign load_req_s = inst_load | data_load;
  assign link_addr  = pc_r + PC_W'(1);
  // Offset is sign-extended (or truncated) to PC width; the sum wraps mod 2^PC_W.
  assign br_off_s   = PC_W'($signed(br_off));
  assign br_tgt_s   = pc_r + PC_W'(1) + br_off_s;
  assign top_idx_s  = IDX_W'(cnt_r - CNT_W'(1));
  assign top_s      = ras_mem_r[top_idx_s];

  assign pc_curr   = pc_r;
  assign state     = state_r;
  assign ras_empty = (cnt_r == CNT_W'(0));
  assign ras_full  = (cnt_r == CNT_W'(RAS_DEPTH));
  assign ras_ovf   = ovf_r;
  assign ras_unf   = unf_r;

  // Next-state, next-PC and stack-control decode in priority order.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    cnt_nxt_s   = cnt_r;
    push_s      = 1'b0;
    ovf_set_s   = 1'b0;
    unf_set_s   = 1'b0;
    case (state_r)
      ST_RUN, ST_HALT: begin
        if (load_req_s) begin
          state_nxt_s = ST_LOAD;
          pc_nxt_s    = '0;
        end else if (state_r == ST_HALT) begin
          pc_nxt_s = pc_r;
        end else if (stall) begin
          pc_nxt_s = pc_r;
        end else if (halt) begin
          state_nxt_s = ST_HALT;
        end else if (is_jump == 2'b10) begin
          case (jmp_sel)
            2'b00: pc_nxt_s = jmp_tgt;
            2'b01: pc_nxt_s = reg_tgt;
            2'b10: begin
              pc_nxt_s = jmp_tgt;
              if (ras_full) begin
                ovf_set_s = 1'b1;
              end else begin
                push_s    = 1'b1;
                cnt_nxt_s = cnt_r + CNT_W'(1);
              end
            end
            2'b11: begin
              if (ras_empty) begin
                pc_nxt_s  = reg_tgt;
                unf_set_s = 1'b1;
              end else begin
                pc_nxt_s  = top_s;
                cnt_nxt_s = cnt_r - CNT_W'(1);
              end
            end
            default: pc_nxt_s = pc_r + PC_W'(1);
          endcase
        end else if ((is_jump == 2'b01) && br_taken) begin
          pc_nxt_s = br_tgt_s;
        end else begin
          pc_nxt_s = pc_r + PC_W'(1);
        end
      end
      ST_LOAD: begin
        if (load_req_s) begin
          if (load_valid) begin
            pc_nxt_s = pc_r + PC_W'(1);
          end else begin
            pc_nxt_s = pc_r;
          end
        end else begin
          state_nxt_s = ST_RUN;
          pc_nxt_s    = '0;
          cnt_nxt_s   = '0;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
        pc_nxt_s    = '0;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Control state, PC, stack depth and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
      pc_r    <= '0;
      cnt_r   <= '0;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ovf_r   <= ovf_r | ovf_set_s;
      unf_r   <= unf_r | unf_set_s;
    end
  end

  // Return-address storage; contents past the depth counter are don't-care.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      ras_mem_r[cnt_r[IDX_W-1:0]] <= link_addr;
    end
  end

endmodule
